read_engine: RTL and testbench

//  Memcpy source-side engine; sits directly upstream of write_engine in the CU.

---
 rtl/read_engine_pkg.sv | 105 ++++++++++
 rtl/read_engine.sv | 145 ++++++++++++++
 tb/tb_read_engine.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/read_engine_pkg.sv
// Shared types and helpers for the read-side memcpy engine.
// Holds the command/response/WED/status buffer line types, the engine FSM
// encoding, cacheline geometry constants and cmd_size_calculate.
package read_engine_pkg;

  localparam int unsigned ARRAY_SIZE_BITS = 32;
  localparam int unsigned ADDRESS_BITS    = 64;
  localparam int unsigned CU_ID_BITS      = 8;
  localparam int unsigned CACHELINE_SIZE  = 128;  // bytes
  localparam int unsigned CACHELINE_ELEMS = 32;   // 4-byte elements per cacheline

  localparam logic [CU_ID_BITS-1:0] DATA_READ_CONTROL_ID = 8'h11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } read_engine_state;

  typedef enum logic [12:0] {
    READ_CL_NA = 13'h0A00,
    WRITE_NA   = 13'h0D00
  } command_type;

  typedef enum logic [1:0] {
    STRICT = 2'b00,
    ABORT  = 2'b01,
    PAGE   = 2'b10,
    SPEC   = 2'b11
  } trans_order_type;

  typedef enum logic [1:0] {
    CMD_INVALID = 2'd0,
    CMD_READ    = 2'd1,
    CMD_WRITE   = 2'd2
  } cmd_type_t;

  typedef enum logic [1:0] {
    STRUCT_INVALID = 2'd0,
    READ_DATA      = 2'd1,
    WRITE_DATA     = 2'd2
  } array_struct_type;

  typedef struct packed {
    logic [CU_ID_BITS-1:0]   cu_id_x;
    logic [CU_ID_BITS-1:0]   cu_id_y;
    cmd_type_t               cmd_type;
    array_struct_type        array_struct;
    trans_order_type         abt;
    logic [ADDRESS_BITS-1:0] address_offset;
    logic [6:0]              cacheline_offset;
    logic [7:0]              real_size;
    logic [9:0]              real_size_bytes;
  } CommandTagLine;

  typedef struct packed {
    logic                    valid;
    command_type             command;
    logic [ADDRESS_BITS-1:0] address;
    logic [11:0]             size;
    CommandTagLine           cmd;
  } CommandBufferLine;

  typedef struct packed {
    logic [ADDRESS_BITS-1:0]    array_send;
    logic [ARRAY_SIZE_BITS-1:0] size_send;
  } WEDStruct;

  typedef struct packed {
    logic     valid;
    WEDStruct wed;
  } WEDInterface;

  typedef struct packed {
    CommandTagLine cmd;
    logic [7:0]    response;
  } ResponsePayload;

  typedef struct packed {
    logic           valid;
    ResponsePayload payload;
  } ResponseBufferLine;

  typedef struct packed {
    logic valid;
    logic empty;
    logic alfull;
    logic full;
  } BufferStatus;

  // Transfer size in bytes, rounded up to the next power of two.
  function automatic logic [11:0] cmd_size_calculate(input logic [7:0] real_size);
    logic [11:0] bytes;
    logic [11:0] sz;
    bytes = {2'b00, real_size, 2'b00};
    sz    = 12'd1;
    for (int unsigned i = 0; i < 12; i++) begin
      if (sz < bytes) sz = sz << 1;
    end
    return sz;
  endfunction

endpackage

// File: rtl/read_engine.sv
// Memcpy source-side engine. Walks wed.array_send in cacheline chunks,
// issuing READ_CL_NA commands, and counts elements returned by responses.
// Ports:
//   clock, rstn                 clock, asynchronous active-low reset
//   read_enabled_in             engine enable (registered before use)
//   wed_request_in              work element descriptor (array_send, size_send)
//   read_response_in            read responses; payload.cmd.real_size counted
//   read_command_buffer_status  command buffer status; alfull stalls issue
//   read_command_out            read command to the command arbiter
//   read_job_counter_done       elements whose read has completed
module read_engine
  import read_engine_pkg::*;
#(
  parameter logic [CU_ID_BITS-1:0] CU_READ_CONTROL_ID = DATA_READ_CONTROL_ID
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       read_enabled_in,
  input  WEDInterface                wed_request_in,
  input  ResponseBufferLine          read_response_in,
  input  BufferStatus                read_command_buffer_status,
  output CommandBufferLine           read_command_out,
  output logic [ARRAY_SIZE_BITS-1:0] read_job_counter_done
);

  logic                       enabled_in;
  WEDInterface                wed_latched;
  ResponseBufferLine          response_latched;
  BufferStatus                status_latched;

  read_engine_state           state;
  logic [ADDRESS_BITS-1:0]    array_send;
  logic [ARRAY_SIZE_BITS-1:0] size_total;
  logic [ARRAY_SIZE_BITS-1:0] remaining;
  logic [ADDRESS_BITS-1:0]    offset;

  logic                       issue;
  logic [7:0]                 chunk;
  logic [ARRAY_SIZE_BITS-1:0] chunk_ext;
  CommandBufferLine           cmd_next;
  CommandBufferLine           issue_line;

  logic                       unused_bits;
  assign unused_bits = ^{status_latched, response_latched};

  // Input stage: payloads follow the inputs every cycle, valids only when enabled.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled_in             <= 1'b0;
      wed_latched.valid      <= 1'b0;
      response_latched.valid <= 1'b0;
      status_latched.valid   <= 1'b0;
      status_latched.empty   <= 1'b1;
      status_latched.alfull  <= 1'b0;
      status_latched.full    <= 1'b0;
    end else begin
      enabled_in              <= read_enabled_in;
      wed_latched.wed         <= wed_request_in.wed;
      response_latched.payload <= read_response_in.payload;
      status_latched.empty    <= read_command_buffer_status.empty;
      status_latched.alfull   <= read_command_buffer_status.alfull;
      status_latched.full     <= read_command_buffer_status.full;
      if (enabled_in) begin
        wed_latched.valid      <= wed_request_in.valid;
        response_latched.valid <= read_response_in.valid;
        status_latched.valid   <= read_command_buffer_status.valid;
      end
    end
  end

  assign chunk     = (remaining < CACHELINE_ELEMS) ? remaining[7:0] : 8'(CACHELINE_ELEMS);
  assign chunk_ext = ARRAY_SIZE_BITS'(chunk);
  assign issue     = (state == ISSUE) && enabled_in && !status_latched.alfull &&
                     (remaining != '0);

  always_comb begin
    cmd_next                      = '0;
    cmd_next.valid                = issue;
    cmd_next.command              = READ_CL_NA;
    cmd_next.address              = array_send + offset;
    cmd_next.size                 = cmd_size_calculate(chunk);
    cmd_next.cmd.cu_id_x          = CU_READ_CONTROL_ID;
    cmd_next.cmd.cu_id_y          = CU_READ_CONTROL_ID;
    cmd_next.cmd.cmd_type         = CMD_READ;
    cmd_next.cmd.array_struct     = READ_DATA;
    cmd_next.cmd.abt              = STRICT;
    cmd_next.cmd.address_offset   = offset;
    cmd_next.cmd.cacheline_offset = '0;
    cmd_next.cmd.real_size        = chunk;
    cmd_next.cmd.real_size_bytes  = {chunk, 2'b00};
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      array_send <= '0;
      size_total <= '0;
      remaining  <= '0;
      offset     <= '0;
    end else if (enabled_in) begin
      case (state)
        IDLE: if (wed_latched.valid) state <= SETUP;
        SETUP: begin
          array_send <= wed_latched.wed.array_send;
          size_total <= wed_latched.wed.size_send;
          remaining  <= wed_latched.wed.size_send;
          offset     <= '0;
          state      <= (wed_latched.wed.size_send == '0) ? DONE : ISSUE;
        end
        ISSUE: begin
          if (issue) begin
            remaining <= remaining - chunk_ext;
            offset    <= offset + ADDRESS_BITS'(CACHELINE_SIZE);
            if (remaining == chunk_ext) state <= WAIT;
          end
        end
        WAIT:  if (read_job_counter_done == size_total) state <= DONE;
        DONE:  state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Issue register and output register both hold while disabled, so a command
  // in flight when the enable drops is emitted once after it returns.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      issue_line.valid       <= 1'b0;
      read_command_out.valid <= 1'b0;
    end else if (enabled_in) begin
      issue_line       <= cmd_next;
      read_command_out <= issue_line;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      read_job_counter_done <= '0;
    end else if (enabled_in && response_latched.valid) begin
      read_job_counter_done <= read_job_counter_done +
                               ARRAY_SIZE_BITS'(response_latched.payload.cmd.real_size);
    end
  end

endmodule

// File: tb/tb_read_engine.sv
// Scoreboard bench for read_engine: directed WED jobs push expected commands,
// a negedge monitor pops and compares each freshly emitted command.
module tb_read_engine;
  import read_engine_pkg::*;

  localparam logic [CU_ID_BITS-1:0] TB_CU_ID = 8'h22;

  logic                       clock = 1'b0;
  logic                       rstn;
  logic                       read_enabled_in;
  WEDInterface                wed_request_in;
  ResponseBufferLine          read_response_in;
  BufferStatus                read_command_buffer_status;
  CommandBufferLine           read_command_out;
  logic [ARRAY_SIZE_BITS-1:0] read_job_counter_done;

  always #5 clock = ~clock;

  read_engine #(.CU_READ_CONTROL_ID(TB_CU_ID)) dut (
    .clock                      (clock),
    .rstn                       (rstn),
    .read_enabled_in            (read_enabled_in),
    .wed_request_in             (wed_request_in),
    .read_response_in           (read_response_in),
    .read_command_buffer_status (read_command_buffer_status),
    .read_command_out           (read_command_out),
    .read_job_counter_done      (read_job_counter_done)
  );

  typedef struct {
    logic [63:0] address;
    logic [7:0]  real_size;
    logic [9:0]  bytes;
    logic [63:0] offset;
    logic [11:0] size;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   seen   = 0;

  // Bench-side model of the enable pipeline: the output register takes a new
  // value only on edges where the registered enable was high.
  logic en_q, en_qq;
  always @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      en_q  <= 1'b0;
      en_qq <= 1'b0;
    end else begin
      en_q  <= read_enabled_in;
      en_qq <= en_q;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rstn && en_qq && read_command_out.valid) begin
      seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_command: got address 0x%0h expected none",
                 read_command_out.address);
      end else begin
        mon_e = sb.pop_front();
        check("cmd_address",      read_command_out.address,                  mon_e.address);
        check("cmd_real_size",    read_command_out.cmd.real_size,            mon_e.real_size);
        check("cmd_bytes",        read_command_out.cmd.real_size_bytes,      mon_e.bytes);
        check("cmd_addr_offset",  read_command_out.cmd.address_offset,       mon_e.offset);
        check("cmd_size",         read_command_out.size,                     mon_e.size);
        check("cmd_command",      read_command_out.command,                  READ_CL_NA);
        check("cmd_cl_offset",    read_command_out.cmd.cacheline_offset,     0);
        check("cmd_array_struct", read_command_out.cmd.array_struct,         READ_DATA);
        check("cmd_type",         read_command_out.cmd.cmd_type,             CMD_READ);
        check("cmd_abt",          read_command_out.cmd.abt,                  STRICT);
        check("cmd_cu_id",        {read_command_out.cmd.cu_id_x, read_command_out.cmd.cu_id_y},
                                  {TB_CU_ID, TB_CU_ID});
      end
    end
  end

  task automatic push(input logic [63:0] addr, input logic [7:0] rs,
                      input logic [63:0] off, input logic [11:0] sz);
    exp_t e;
    e.address   = addr;
    e.real_size = rs;
    e.bytes     = 10'(rs) * 10'd4;
    e.offset    = off;
    e.size      = sz;
    sb.push_back(e);
  endtask

  task automatic do_reset(input string name);
    rstn = 1'b0;
    read_enabled_in = 1'b1;
    wed_request_in = '0;
    read_response_in = '0;
    read_command_buffer_status = '0;
    read_command_buffer_status.empty = 1'b1;
    sb.delete();
    seen = 0;
    repeat (2) @(posedge clock);
    #1;
    check({name, "_reset_valid"}, read_command_out.valid, 0);
    check({name, "_reset_done"},  read_job_counter_done, 0);
    rstn = 1'b1;
  endtask

  task automatic send_wed(input logic [63:0] arr, input logic [31:0] sz);
    @(posedge clock);
    #1;
    wed_request_in.valid          = 1'b1;
    wed_request_in.wed.array_send = arr;
    wed_request_in.wed.size_send  = sz;
    @(posedge clock);
    #1;
    wed_request_in.valid = 1'b0;
  endtask

  task automatic send_resp(input logic [7:0] rs);
    @(posedge clock);
    #1;
    read_response_in.valid                 = 1'b1;
    read_response_in.payload.cmd.real_size = rs;
    @(posedge clock);
    #1;
    read_response_in.valid = 1'b0;
  endtask

  task automatic wait_seen(input int n, input int budget, input string name);
    for (int i = 0; i < budget && seen < n; i++) @(posedge clock);
    #1;
    check({name, "_cmd_count"}, seen, n);
    check({name, "_sb_empty"},  sb.size(), 0);
  endtask

  task automatic check_done(input logic [31:0] exp, input string name);
    repeat (3) @(posedge clock);
    #1;
    check(name, read_job_counter_done, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: two full cachelines, latency, completion, DONE holds
    do_reset("t1");
    push(64'h1000, 8'd32, 64'd0,   12'd128);
    push(64'h1080, 8'd32, 64'd128, 12'd128);
    send_wed(64'h1000, 32'd64);
    repeat (3) @(posedge clock);
    #1 check("t1_latency_early", read_command_out.valid, 0);
    @(posedge clock);
    #1 check("t1_latency_valid", read_command_out.valid, 1);
    wait_seen(2, 50, "t1");
    send_resp(8'd32);
    send_resp(8'd32);
    check_done(32'd64, "t1_done");
    send_wed(64'h5000, 32'd64);
    repeat (12) @(posedge clock);
    #1 check("t1_done_holds", seen, 2);

    // 2: partial final cacheline
    do_reset("t2");
    push(64'h2000, 8'd32, 64'd0,   12'd128);
    push(64'h2080, 8'd8,  64'd128, 12'd32);
    send_wed(64'h2000, 32'd40);
    wait_seen(2, 50, "t2");
    send_resp(8'd32);
    send_resp(8'd8);
    check_done(32'd40, "t2_done");

    // 3: empty job goes straight to DONE
    do_reset("t3");
    send_wed(64'h3000, 32'd0);
    repeat (12) @(posedge clock);
    #1 check("t3_no_cmd", seen, 0);
    check("t3_done_zero", read_job_counter_done, 0);
    send_wed(64'h3000, 32'd64);
    repeat (12) @(posedge clock);
    #1 check("t3_done_holds", seen, 0);

    // 4: alfull stall right after the first issue
    do_reset("t4");
    push(64'h4000, 8'd32, 64'd0,   12'd128);
    push(64'h4080, 8'd32, 64'd128, 12'd128);
    push(64'h4100, 8'd32, 64'd256, 12'd128);
    send_wed(64'h4000, 32'd96);
    repeat (2) @(posedge clock);
    #1 read_command_buffer_status.alfull = 1'b1;
    repeat (5) @(posedge clock);
    #1 check("t4_stalled_count", seen, 1);
    read_command_buffer_status.alfull = 1'b0;
    wait_seen(3, 50, "t4");
    repeat (10) @(posedge clock);
    #1 check("t4_exact_count", seen, 3);

    // 5: enable dropped mid-job for 4 cycles
    do_reset("t5");
    push(64'h6000, 8'd32, 64'd0,   12'd128);
    push(64'h6080, 8'd32, 64'd128, 12'd128);
    push(64'h6100, 8'd32, 64'd256, 12'd128);
    send_wed(64'h6000, 32'd96);
    repeat (2) @(posedge clock);
    #1 read_enabled_in = 1'b0;
    repeat (4) @(posedge clock);
    #1 check("t5_frozen_count", seen, 0);
    check("t5_frozen_valid", read_command_out.valid, 0);
    read_enabled_in = 1'b1;
    wait_seen(3, 50, "t5");
    send_resp(8'd32);
    send_resp(8'd32);
    send_resp(8'd32);
    check_done(32'd96, "t5_done");
    repeat (10) @(posedge clock);
    #1 check("t5_no_dup", seen, 3);

    // 6: reset right after the first command, then restart
    do_reset("t6");
    send_resp(8'd8);
    check_done(32'd8, "t6_done_pre");
    push(64'h7000, 8'd32, 64'd0, 12'd128);
    send_wed(64'h7000, 32'd64);
    for (int i = 0; i < 50 && seen < 1; i++) begin
      @(negedge clock);
      #1;
    end
    rstn = 1'b0;
    #1;
    check("t6_rst_valid", read_command_out.valid, 0);
    check("t6_rst_done",  read_job_counter_done, 0);
    check("t6_first_seen", seen, 1);
    sb.delete();
    seen = 0;
    repeat (2) @(posedge clock);
    #1 rstn = 1'b1;
    push(64'h8000, 8'd32, 64'd0,   12'd128);
    push(64'h8080, 8'd32, 64'd128, 12'd128);
    send_wed(64'h8000, 32'd64);
    wait_seen(2, 50, "t6");
    send_resp(8'd32);
    send_resp(8'd32);
    check_done(32'd64, "t6_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
